// File: rtl/pmem_line_responder.sv
// Converts 256-bit cache-line reads/writes into 4-beat 64-bit memory bursts; line_resp
// follows the last beat by one cycle, and mem_resp low stretches the burst with the beat count held.
module pmem_line_responder #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_read,
  input  logic                line_write,
  input  logic [31:0]         line_address,
  input  logic [s_line-1:0]   line_wdata,
  output logic [s_line-1:0]   line_rdata,
  output logic                line_resp,
  output logic                mem_read,
  output logic                mem_write,
  output logic [31:0]         mem_address,
  output logic [s_burst-1:0]  mem_wdata,
  input  logic [s_burst-1:0]  mem_rdata,
  input  logic                mem_resp
);

  localparam int num_beats = s_line / s_burst;
  localparam int cnt_w     = (num_beats > 1) ? $clog2(num_beats) : 1;
  localparam logic [cnt_w-1:0] last_beat = cnt_w'(num_beats - 1);
  localparam logic [31:0] off_mask = (32'd1 << s_offset) - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [s_line-1:0]   buf_q, buf_d;
  logic [31:0]         addr_q, addr_d;
  logic [s_line-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Writeback takes priority when both requests arrive together.
        if (line_write) begin
          buf_d   = line_wdata;
          addr_d  = line_address & ~off_mask;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (line_read) begin
          addr_d  = line_address & ~off_mask;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (mem_resp) begin
          buf_d[cnt_q*s_burst +: s_burst] = mem_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            rdata_d = buf_d;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_read    = (state_q == READ);
  assign mem_write   = (state_q == WRITE);
  assign mem_address = (mem_read || mem_write) ? addr_q : 32'd0;
  assign mem_wdata   = mem_write ? buf_q[cnt_q*s_burst +: s_burst] : '0;
  assign line_resp   = (state_q == DONE);
  assign line_rdata  = rdata_q;

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Responder end of the 256-bit cache-line memory port that the instruction and data caches drive (`pmem_read`, `pmem_write`, `pmem_address`, `pmem_wdata`, `pmem_rdata`, `pmem_resp`).
- Each line request is converted into a burst of 64-bit beats on the physical-memory bus.
- Sits between the cache-side arbiter and main memory.
- Gathers read beats into a full line, splits write lines into beats, and returns one `line_resp` per completed line.

Parameters:
- s_line, 256: cache line width in bits.
- s_burst, 64: memory beat width in bits.
- num_beats, s_line/s_burst (4): beats per line.
- s_offset, 5: byte-offset bits cleared on the outgoing address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- line_read  input  1  cache requests a line fill.
- line_write  input  1  cache requests a line writeback.
- line_address  input  32  line address from cache.
- line_wdata  input  256  line to write.
- line_rdata  output  256  assembled fill line.
- line_resp  output  1  one-cycle completion pulse.
- mem_read  output  1  burst read request to memory.
- mem_write  output  1  burst write request to memory.
- mem_address  output  32  line-aligned burst address.
- mem_wdata  output  64  current write beat.
- mem_rdata  input  64  current read beat.
- mem_resp  input  1  beat accepted (write) or beat valid (read).

Behaviour:
- Reset (rst low, asynchronous, any state): state=IDLE, beat counter=0, line_resp=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, line_rdata=0, internal line buffer=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - line_write=1 -> latch line_wdata into buffer, latch {line_address[31:5],5'b0}, counter=0, go to WRITE.
  - Else line_read=1 -> latch address the same way, counter=0, go to READ.
  - If both are high, write wins; read is not serviced for this request.
  - mem_resp is ignored in IDLE.
- READ:
  - mem_read=1, mem_address=latched address.
  - Each cycle with mem_resp=1: buffer[64*k+63 : 64*k] <= mem_rdata (k=counter), counter++.
  - Gaps (mem_resp=0) between beats are legal; the counter holds across them.
  - On the beat where counter==num_beats-1: go to DONE. mem_read deasserts in the cycle after the last beat.
- WRITE:
  - mem_write=1, mem_address=latched address, mem_wdata=buffer slice k (combinational from counter).
  - Each mem_resp=1 advances counter; same gap rule as READ.
  - Last beat -> DONE.
- DONE:
  - line_resp=1 for exactly one cycle; mem_read=mem_write=0.
  - After a read, line_rdata=assembled buffer.
  - Next state IDLE unconditionally. line_read/line_write are ignored during DONE.
  - A request still high in the following IDLE cycle is a new request; the cache drops its request in the cycle after line_resp.
- line_rdata is registered. It holds the last completed fill until the next read completes; writes do not alter it.
- line_* inputs are ignored outside IDLE; latched values are used throughout the burst.
- Latency with no gaps:
  - Read: accept cycle + 4 beat cycles, then line_resp in the 6th cycle after request assertion.
  - Write: same.
- Counter is log2(num_beats) bits and wraps to 0 on the last beat.
- mem_read and mem_write are never high simultaneously.
- Reset asserted mid-burst aborts the burst with no line_resp. After release, the block accepts a fresh request from IDLE.

Test Plan:
- Reset release, no requests, 10 cycles -> all outputs 0, no mem_read/mem_write.
- Read fill:
  - Stimulus: line_read=1, line_address=0x0000_1234; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive cycles.
  - Required: mem_address=0x0000_1220.
  - Required: line_rdata = {0x4444...,0x3333...,0x2222...,0x1111...}.
  - Required: line_resp one cycle, 6th cycle after request.
- Writeback:
  - Stimulus: line_write=1, line_wdata=256'h{D,C,B,A} 64-bit words, address 0x8000_0040.
  - Required: mem_wdata = A,B,C,D in beat order.
  - Required: mem_address = 0x8000_0040; line_resp once; line_rdata unchanged.
- Gapped read: mem_resp pattern 1,0,0,1,1,0,1 -> four beats captured in order; line_resp exactly one cycle after the 4th mem_resp.
- Simultaneous line_read=1 and line_write=1 in IDLE -> WRITE burst performed (mem_write=1, mem_read=0 throughout); one line_resp.
- Reset mid-burst:
  - Stimulus: rst low after 2 read beats, then released; new read issued with beats 0x5...,0x6...,0x7...,0x8....
  - Required: no line_resp during abort; outputs 0 immediately on reset.
  - Required: line_rdata = {0x8...,0x7...,0x6...,0x5...}, with no stale beats.
